// File: rtl/pipe_wb_regfile.sv
// pipe_wb_regfile: write-back stage that selects wdi, commits it to the register file, serves bypassed read ports qa/qb and debug port dbg_q, and counts retired writes in wb_count
module pipe_wb_regfile #(
  parameter int DW = 32,
  parameter int AW = 5,
  parameter bit BYPASS = 1
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          wwreg,
  input  logic          wm2reg,
  input  logic [DW-1:0] wmo,
  input  logic [DW-1:0] walu,
  input  logic [AW-1:0] wrn,
  input  logic [AW-1:0] rna,
  input  logic [AW-1:0] rnb,
  output logic [DW-1:0] qa,
  output logic [DW-1:0] qb,
  output logic [DW-1:0] wdi,
  input  logic [AW-1:0] dbg_rn,
  output logic [DW-1:0] dbg_q,
  output logic [31:0]   wb_count
);
  logic [DW-1:0] r_rf [0:2**AW-1];
  logic [31:0]   r_wb_count;
  logic          w_commit;
  logic          w_byp;
  assign wdi      = wm2reg ? wmo : walu;
  assign w_commit = wwreg && (wrn != '0) && resetn;
  assign w_byp    = BYPASS && wwreg && resetn;
  assign wb_count = r_wb_count;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 2**AW; i++) r_rf[i] <= '0;
      r_wb_count <= '0;
    end else if (w_commit) begin
      r_rf[wrn]  <= wdi;
      r_wb_count <= r_wb_count + 32'd1;
    end
  end
  always_comb begin
    qa    = (rna == '0) ? '0 : (w_byp && wrn == rna) ? wdi : r_rf[rna];
    qb    = (rnb == '0) ? '0 : (w_byp && wrn == rnb) ? wdi : r_rf[rnb];
    dbg_q = (dbg_rn == '0) ? '0 : r_rf[dbg_rn];
  end
endmodule

// File: tb/tb_pipe_wb_regfile.sv
// tb_pipe_wb_regfile: scoreboard bench for pipe_wb_regfile with bypass on and off
module tb_pipe_wb_regfile;
  logic        clk = 0;
  logic        resetn;
  logic        wwreg, wm2reg;
  logic [31:0] wmo, walu;
  logic [4:0]  wrn, rna, rnb, dbg_rn;
  logic [31:0] qa, qb, wdi, dbg_q, wb_count;
  logic [31:0] qa0, qb0, wdi0, dbg_q0, wb_count0;
  int checks = 0, errors = 0;
  logic [31:0] mcnt;
  typedef struct {logic [4:0] rn; logic [31:0] val; logic [31:0] cnt;} exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  pipe_wb_regfile #(.DW(32), .AW(5), .BYPASS(1)) dut (
    .clk(clk), .resetn(resetn), .wwreg(wwreg), .wm2reg(wm2reg), .wmo(wmo), .walu(walu),
    .wrn(wrn), .rna(rna), .rnb(rnb), .qa(qa), .qb(qb), .wdi(wdi),
    .dbg_rn(dbg_rn), .dbg_q(dbg_q), .wb_count(wb_count));

  pipe_wb_regfile #(.DW(32), .AW(5), .BYPASS(0)) u0 (
    .clk(clk), .resetn(resetn), .wwreg(wwreg), .wm2reg(wm2reg), .wmo(wmo), .walu(walu),
    .wrn(wrn), .rna(rna), .rnb(rnb), .qa(qa0), .qb(qb0), .wdi(wdi0),
    .dbg_rn(dbg_rn), .dbg_q(dbg_q0), .wb_count(wb_count0));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic drive_wb(input logic en, input logic m2r, input logic [31:0] mo,
                          input logic [31:0] alu, input logic [4:0] rn);
    logic [31:0] v;
    v = m2r ? mo : alu;
    wwreg = en; wm2reg = m2r; wmo = mo; walu = alu; wrn = rn;
    if (en && rn != 0) sb.push_back('{rn, v, mcnt + 32'd1});
  endtask

  task automatic commit_edge();
    exp_t e;
    @(posedge clk);
    #1;
    wwreg = 0;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      dbg_rn = e.rn;
      mcnt = e.cnt;
      #1;
      check("commit_data", dbg_q, e.val);
    end else #1;
    check("wb_count", wb_count, mcnt);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    resetn = 0; wwreg = 0; wm2reg = 0; wmo = 32'h11; walu = 32'h22; wrn = 0;
    rna = 5; rnb = 3; dbg_rn = 5; mcnt = 0;
    #12;
    check("rst_qa", qa, 0);
    check("rst_dbg", dbg_q, 0);
    check("rst_cnt", wb_count, 0);
    check("rst_wdi", wdi, 32'h22);
    @(negedge clk); resetn = 1;
    @(negedge clk);

    drive_wb(1, 0, 32'h0, 32'h12345678, 3);
    #1 check("mux_alu", wdi, 32'h12345678);
    commit_edge();
    drive_wb(1, 1, 32'hCAFEF00D, 32'h0, 3);
    #1 check("mux_mem", wdi, 32'hCAFEF00D);
    commit_edge();

    drive_wb(1, 0, 32'h0, 32'hFFFFFFFF, 0);
    rna = 0; dbg_rn = 0;
    #1 check("r0_qa_pre", qa, 0);
    commit_edge();
    check("r0_qa", qa, 0);
    check("r0_dbg", dbg_q, 0);

    drive_wb(1, 0, 32'h0, 32'h1, 7);
    commit_edge();
    drive_wb(1, 0, 32'h0, 32'h2, 7);
    rna = 7; rnb = 7; dbg_rn = 7;
    #1;
    check("byp_qa", qa, 32'h2);
    check("byp_qb", qb, 32'h2);
    check("byp_dbg", dbg_q, 32'h1);
    check("nobyp_qa", qa0, 32'h1);
    check("nobyp_qb", qb0, 32'h1);
    commit_edge();
    check("byp_after", dbg_q, 32'h2);
    check("nobyp_after", dbg_q0, 32'h2);
    check("nobyp_cnt", wb_count0, mcnt);

    for (int i = 0; i < 3; i++) begin
      drive_wb(0, 0, 32'h0, 32'h55, 9);
      #1 check("dis_wdi", wdi, 32'h55);
      commit_edge();
      dbg_rn = 9;
      #1 check("dis_r9", dbg_q, 0);
    end

    drive_wb(1, 0, 32'h0, 32'hDEADBEEF, 5);
    commit_edge();
    rna = 5;
    #1 check("pre_rst_qa", qa, 32'hDEADBEEF);
    @(posedge clk); #2;
    drive_wb(1, 0, 32'h0, 32'h77, 5);
    sb.delete();
    resetn = 0;
    #1;
    check("mid_rst_qa", qa, 0);
    check("mid_rst_cnt", wb_count, 0);
    check("mid_rst_wdi", wdi, 32'h77);
    @(posedge clk); #1;
    check("rst_edge_cnt", wb_count, 0);
    dbg_rn = 5;
    #1 check("rst_edge_r5", dbg_q, 0);
    wwreg = 0; mcnt = 0;
    @(negedge clk); resetn = 1;
    @(negedge clk);

    force dut.r_wb_count = 32'hFFFFFFFF;
    #1 release dut.r_wb_count;
    #1 check("preload", wb_count, 32'hFFFFFFFF);
    mcnt = 32'hFFFFFFFF;
    drive_wb(1, 0, 32'h0, 32'hA, 4);
    commit_edge();
    check("wrap", wb_count, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
